// File: rtl/mdio_target.sv
// Clause-22 MDIO responder: oversamples MDC/MDIO, decodes frames for phy_addr,
// and bridges them onto a 32 x 16-bit register bus.
module mdio_target #(
  parameter int PREAMBLE_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  phy_addr,
  input  logic        mdc,
  input  logic        mdio_rx_data,
  output logic        mdio_tx_data,
  output logic        mdio_tx_en,
  output logic        rd_en,
  output logic [4:0]  rd_addr,
  input  logic        rd_valid,
  input  logic [15:0] rd_data,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_err
);
  typedef enum logic [2:0] {IDLE, ST1, OP, PHYAD, REGAD, TA, DATA} state_t;
  localparam logic [5:0] PRE = 6'(PREAMBLE_BITS);

  state_t      state, state_nxt;
  logic [1:0]  mdc_sync, mdio_sync;
  logic        mdc_prev, ev, bit_in;
  logic [5:0]  pre_cnt;
  logic [4:0]  cnt, reg_sh;
  logic [3:0]  phy_sh;
  logic        op0, is_rd, match, rd_wait, tx_en_q, tx_data_q;
  logic [15:0] sh;
  logic        op_ok, err_nxt, rd_nxt, wr_nxt, rd_shift;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mdc_sync  <= '0;
      mdio_sync <= '0;
      mdc_prev  <= 1'b0;
    end else begin
      mdc_sync  <= {mdc_sync[0], mdc};
      mdio_sync <= {mdio_sync[0], mdio_rx_data};
      mdc_prev  <= mdc_sync[1];
    end

  assign ev     = mdc_sync[1] & ~mdc_prev;
  assign bit_in = mdio_sync[1];
  assign op_ok  = op0 ^ bit_in;  // only 10 and 01 are legal opcodes

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (ev) begin
      case (state)
        IDLE:    if (!bit_in && pre_cnt >= PRE) state_nxt = ST1;
        ST1:     state_nxt = bit_in ? OP : IDLE;
        OP:      if (cnt[0]) state_nxt = op_ok ? PHYAD : IDLE;
        PHYAD:   if (cnt == 5'd4) state_nxt = REGAD;
        REGAD:   if (cnt == 5'd4) state_nxt = match ? TA : IDLE;
        TA:      if (is_rd || cnt[0]) state_nxt = DATA;
        DATA:    if (cnt == (is_rd ? 5'd16 : 5'd15)) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    err_nxt  = 1'b0;
    rd_nxt   = 1'b0;
    wr_nxt   = 1'b0;
    rd_shift = 1'b0;
    if (ev) begin
      err_nxt  = (state == ST1 && !bit_in) || (state == OP && cnt[0] && !op_ok);
      rd_nxt   = state == REGAD && cnt == 5'd4 && match && is_rd;
      wr_nxt   = state == DATA && !is_rd && cnt == 5'd15;
      rd_shift = state == DATA && is_rd && cnt < 5'd16;
    end
  end

  assign mdio_tx_en   = tx_en_q;
  assign mdio_tx_data = tx_data_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_en <= 1'b0; wr_en <= 1'b0; frame_err <= 1'b0;
      rd_addr <= '0; wr_addr <= '0; wr_data <= '0;
      sh <= '0; rd_wait <= 1'b0; cnt <= '0; pre_cnt <= '0;
      op0 <= 1'b0; is_rd <= 1'b0; match <= 1'b0;
      phy_sh <= '0; reg_sh <= '0; tx_en_q <= 1'b0; tx_data_q <= 1'b0;
    end else begin
      rd_en     <= rd_nxt;
      wr_en     <= wr_nxt;
      frame_err <= err_nxt;
      if (rd_nxt) rd_addr <= {reg_sh[3:0], bit_in};
      if (wr_nxt) begin
        wr_addr <= reg_sh;
        wr_data <= {sh[14:0], bit_in};
      end
      // Read data defaults to all-ones; only the first rd_valid before the
      // first driven data bit may replace it.
      if (rd_nxt) begin
        sh      <= '1;
        rd_wait <= 1'b1;
      end else if (rd_shift) begin
        sh      <= {sh[14:0], 1'b1};
        rd_wait <= 1'b0;
      end else if (ev && state == DATA && !is_rd) begin
        sh <= {sh[14:0], bit_in};
      end else if (rd_wait && rd_valid) begin
        sh      <= rd_data;
        rd_wait <= 1'b0;
      end
      if (ev) begin
        cnt     <= (state_nxt != state) ? 5'd0 : cnt + 5'd1;
        pre_cnt <= (state == IDLE && bit_in) ? ((pre_cnt < PRE) ? pre_cnt + 6'd1 : pre_cnt) : 6'd0;
        if (state == OP) begin
          op0 <= bit_in;
          if (cnt[0]) is_rd <= op0;
        end
        if (state == PHYAD) begin
          phy_sh <= {phy_sh[2:0], bit_in};
          if (cnt == 5'd4) match <= ({phy_sh, bit_in} == phy_addr);
        end
        if (state == REGAD) reg_sh <= {reg_sh[3:0], bit_in};
        if (state == TA && is_rd) begin
          tx_en_q   <= 1'b1;
          tx_data_q <= 1'b0;
        end
        if (rd_shift) tx_data_q <= sh[15];
        if (state == DATA && is_rd && cnt == 5'd16) begin
          tx_en_q   <= 1'b0;
          tx_data_q <= 1'b0;
        end
      end
    end
endmodule
